int_sum_squares: RTL and testbench
==================================

# int_sum_squares

Sequential unsigned sum-of-squares unit that computes x² + y² with a shift-add datapath, one multiplier bit per clock. It sits directly upstream of the integer square root block and produces its radicand, so the pair forms a vector-magnitude path. It uses the same start/done handshake as the square root block, so a controller can sequence the two stages identically.

## Interface
- N, default 8: operand width in bits; unsigned operands.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  level request; sampled only in IDLE.
- x  input  N  first operand, unsigned; sampled on the launch edge.
- y  input  N  second operand, unsigned; sampled on the launch edge.
- done  output  1  one-cycle pulse: out is valid.
- out  output  2N+1  x² + y², registered; holds its value until the next result.

## Operation
- States: IDLE, SQ_X, SQ_Y.
- **IDLE**
  - If start=1: latch x and y into xr/yr, clear acc, clear cnt, go to SQ_X. This is the launch edge.
  - Otherwise stay in IDLE.
- **SQ_X**
  - Each cycle: if xr[cnt] is set, acc += xr << cnt.
  - cnt increments each cycle. When cnt=N-1: reset cnt to 0 and go to SQ_Y.
- **SQ_Y**
  - Same step using yr.
  - When cnt=N-1: out <= final acc (including this step), done <= 1, go to IDLE.
- **Widths**
  - acc is 2N+1 bits. Partial products are zero-extended to 2N+1 bits.
  - Maximum result is 2(2^N−1)² < 2^(2N+1), so no overflow is possible and no saturation is needed.
- **Start handling**
  - start is ignored in SQ_X and SQ_Y.
  - x and y may change freely after the launch edge.
- **Back-to-back:** if start=1 in the cycle where done=1, that cycle is IDLE, so the next operation launches on that edge.
- **Reset**
  - rst=1 on any edge forces: state IDLE, done=0, out=0, acc=0, cnt=0.
  - Reset mid-operation aborts the operation with no done pulse.
  - rst has priority over start.
- **Downstream connection:** the square root consumer is instantiated with width 2N+2. out is zero-extended by one bit to make the width even.

## Timing
- Reset values: done=0, out=0, state IDLE.
- Latency: launch edge e0; x steps on edges e1..eN; y steps on edges eN+1..e2N.
- done=1 in the cycle following e2N, i.e. 2N cycles after the launch edge (16 for N=8).
- done is high for exactly one cycle. out changes only on the edge that raises done.
- Throughput: one result per 2N+1 cycles when start is held high.
- No combinational path from any input to any output.

## Structure
- Shared package int_arith_pkg:
  - typedef enum sq_state_t {IDLE, SQ_X, SQ_Y}.
  - localparam helper function for counter width, $clog2(N), minimum 1.
- Single module, no sub-module. The shift-add step is one always_ff block plus next-state logic.
- Target size: about 120–150 lines.

## Test plan
- N=8, x=3, y=4, start pulsed → done exactly 16 cycles after launch, out=25. Chained into the square root block (width 18), this yields 5.
- x=255, y=255 → out=130050; x=0, y=0 → out=0. done pulses in both cases.
- Mid-operation input changes: start held high and x/y changed to 7/9 during SQ_X → first result is still 25 from 3/4. Because start stays high, the next operation launches immediately and gives 130 (7² + 9²), with done at cycle 33.
- Reset mid-operation: rst asserted at cycle 10 after launching 3/4 → done=0 and out=0 the next cycle, no done pulse. A fresh start with 5/12 → out=169 after 16 cycles.
- Randomized sweep: 1000 random x/y → out equals x*x + y*y. done is never high for two consecutive cycles, and out is stable between done pulses.

Source files
------------

// File: rtl/int_arith_pkg.sv
// Shared definitions for the integer arithmetic blocks (sum of squares, square root).
package int_arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SQ_X,
    SQ_Y
  } sq_state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/int_sum_squares.sv
// Sequential unsigned x^2 + y^2 using shift-add, one multiplier bit per clock.
// Feeds the square root block's radicand; same start/done handshake.
module int_sum_squares
  import int_arith_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic           done,
  output logic [2*N:0]   out
);

  localparam int unsigned W  = 2 * N + 1;
  localparam int unsigned CW = cnt_width(N);

  sq_state_t       state_q, state_d;
  logic [N-1:0]    xr_q, yr_q;
  logic [W-1:0]    acc_q;
  logic [CW-1:0]   cnt_q;

  logic [N-1:0]    opnd;
  logic [W-1:0]    pp;
  logic [W-1:0]    acc_sum;
  logic            last;

  // Partial product for the current multiplier bit of whichever operand is being squared.
  always_comb begin
    opnd    = (state_q == SQ_X) ? xr_q : yr_q;
    pp      = '0;
    if (opnd[cnt_q]) begin
      pp = W'(opnd) << cnt_q;
    end
    acc_sum = acc_q + pp;
    last    = (cnt_q == CW'(N - 1));
  end

  // Next-state logic: x is squared first, then y, then back to idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SQ_X;
      SQ_X:    if (last)  state_d = SQ_Y;
      SQ_Y:    if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture, accumulation, bit counter and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      xr_q  <= '0;
      yr_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      out   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            xr_q  <= x;
            yr_q  <= y;
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        SQ_X: begin
          acc_q <= acc_sum;
          cnt_q <= last ? '0 : cnt_q + CW'(1);
        end
        SQ_Y: begin
          acc_q <= acc_sum;
          cnt_q <= last ? '0 : cnt_q + CW'(1);
          if (last) begin
            out  <= acc_sum;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_sum_squares.sv
// Self-checking bench for int_sum_squares: directed cases plus a randomized sweep,
// checked every cycle against a result-with-countdown model.
module tb_int_sum_squares;

  localparam int unsigned N   = 8;
  localparam int unsigned LAT = 2 * N;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   x;
  logic [N-1:0]   y;
  logic           done;
  logic [2*N:0]   out;

  int n_pass  = 0;
  int n_total = 0;

  int_sum_squares #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Model: a launch accepted while idle yields x*x+y*y exactly LAT edges later;
  // start is ignored while a result is pending; reset discards everything.
  int          busy_left = 0;
  logic [63:0] pend      = 0;
  logic [63:0] exp_out   = 0;
  logic        exp_done  = 1'b0;
  logic        cmp_en    = 1'b0;
  logic        prev_done = 1'b0;

  always @(posedge clk) begin
    exp_done = 1'b0;
    if (rst) begin
      busy_left = 0;
      exp_out   = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        exp_out  = pend;
        exp_done = 1'b1;
      end
    end else if (start) begin
      pend      = 64'(x) * 64'(x) + 64'(y) * 64'(y);
      busy_left = LAT;
    end
    cmp_en = 1'b1;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("done_vs_model", 64'(done), 64'(exp_done));
      check("out_vs_model", 64'(out), exp_out);
      check("done_single_cycle", 64'(prev_done & done), 64'd0);
      prev_done = done;
    end
  end

  // Launch one operation and wait for done; optionally scramble inputs while busy.
  task automatic run_op(input logic [N-1:0] xv, input logic [N-1:0] yv,
                        input logic [63:0] exp, input bit scramble, input string name);
    int n;
    @(posedge clk); #1;
    x = xv; y = yv; start = 1'b1;
    @(posedge clk); #1;  // launch edge just passed
    start = 1'b0;
    n = 0;
    while (n < 4 * LAT) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (scramble) begin
        x     = N'($urandom);
        y     = N'($urandom);
        start = 1'($urandom);
      end
    end
    start = 1'b0;
    check({name, "_latency"}, 64'(n), 64'(LAT));
    check({name, "_out"}, 64'(out), exp);
  endtask

  initial begin
    int n;
    int t1, t2;
    logic [63:0] o1, o2;
    rst = 1'b1; start = 1'b0; x = '0; y = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", 64'(done), 64'd0);
    check("reset_out", 64'(out), 64'd0);
    rst = 1'b0;

    // Hand-computed anchors.
    run_op(8'd3, 8'd4, 64'd25, 1'b0, "x3_y4");
    check("sqrt_chain", 64'(isqrt(int'(out))), 64'd5);
    run_op(8'd255, 8'd255, 64'd130050, 1'b0, "max");
    run_op(8'd0, 8'd0, 64'd0, 1'b0, "zero");

    // Start held high, inputs change during SQ_X; second op launches right after done.
    @(posedge clk); #1;
    x = 8'd3; y = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    n = 0; t1 = -1; t2 = -1; o1 = 0; o2 = 0;
    while (n < 60 && t2 < 0) begin
      @(posedge clk); #1;
      n++;
      if (n == 3) begin
        x = 8'd7; y = 8'd9;
      end
      if (done) begin
        if (t1 < 0) begin
          t1 = n; o1 = 64'(out);
        end else begin
          t2 = n; o2 = 64'(out);
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("held_first_time", 64'(t1), 64'd16);
    check("held_first_out", o1, 64'd25);
    check("held_second_time", 64'(t2), 64'd33);
    check("held_second_out", o2, 64'd130);

    // Reset mid-operation aborts without a done pulse.
    @(posedge clk); #1;
    x = 8'd3; y = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_done", 64'(done), 64'd0);
    check("abort_out", 64'(out), 64'd0);
    rst = 1'b0;
    repeat (LAT + 2) begin
      @(posedge clk); #1;
      check("abort_no_pulse", 64'(done), 64'd0);
    end
    run_op(8'd5, 8'd12, 64'd169, 1'b0, "x5_y12");

    // Randomized sweep with inputs and start scrambled while busy.
    for (int i = 0; i < 1000; i++) begin
      logic [N-1:0] rx, ry;
      rx = N'($urandom);
      ry = N'($urandom);
      run_op(rx, ry, 64'(rx) * 64'(rx) + 64'(ry) * 64'(ry), 1'b1, "rand");
    end

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
